round_robin_arbiter: RTL and testbench

Four-requester round-robin arbiter sharing one resource port among requesters 0–3. A small FSM and a rotating priority pointer hold the winner's 2-bit index. The one-hot grant vector is produced by feeding that index through the existing 2-to-4 `Decoder` block, gated by `busy`. A hold counter bounds how long any single requester keeps the resource while others are waiting.

---
 rtl/round_robin_arbiter_pkg.sv | 13 +
 rtl/round_robin_arbiter_decoder.sv | 16 +
 rtl/round_robin_arbiter.sv | 106 ++++++++++
 tb/tb_round_robin_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/round_robin_arbiter_pkg.sv
// Shared constants and state encoding for the four-requester round-robin arbiter.
package arb_pkg;

   localparam int N_REQ  = 4;
   localparam int ID_W   = 2;
   localparam int HOLD_W = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/round_robin_arbiter_decoder.sv
// Existing 2-to-4 decoder: (w,z) selects one of p,q,r,s (p = 11, s = 00).
module Decoder (
   input  logic w,
   input  logic z,
   output logic p,
   output logic q,
   output logic r,
   output logic s
);

   assign p =  w &  z;
   assign q =  w & ~z;
   assign r = ~w &  z;
   assign s = ~w & ~z;

endmodule

// File: rtl/round_robin_arbiter.sv
// Four-way round-robin arbiter with a bounded hold time under contention;
// the owner index is decoded to a one-hot grant gated by busy.
module round_robin_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             busy
);

   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

   state_t              r_state;
   logic [ID_W-1:0]     r_grant_id;
   logic [ID_W-1:0]     r_last;
   logic [HOLD_W-1:0]   r_hold;

   state_t              w_state_nxt;
   logic [ID_W-1:0]     w_id_nxt;
   logic [ID_W-1:0]     w_last_nxt;
   logic [HOLD_W-1:0]   w_hold_nxt;
   logic [ID_W-1:0]     w_sel_id;
   logic [N_REQ-1:0]    w_dec;
   logic                w_busy;
   logic                w_others;

   // First requester after the pointer; the loop runs backwards so the
   // nearest candidate is written last and wins.
   function automatic logic [ID_W-1:0] f_scan(input logic [N_REQ-1:0] rq,
                                              input logic [ID_W-1:0]  last);
      logic [ID_W-1:0] idx;
      logic [ID_W-1:0] sel;
      sel = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         idx = last + ID_W'(k);
         if (rq[idx]) sel = idx;
      end
      return sel;
   endfunction

   assign w_sel_id = f_scan(req, r_last);
   assign w_busy   = (r_state == ST_GRANT);

   Decoder u_dec (
      .w (r_grant_id[1]),
      .z (r_grant_id[0]),
      .p (w_dec[3]),
      .q (w_dec[2]),
      .r (w_dec[1]),
      .s (w_dec[0])
   );

   // The decoded owner mask doubles as the "someone else is waiting" filter.
   assign w_others = |(req & ~w_dec);

   always_comb begin
      w_state_nxt = r_state;
      w_id_nxt    = r_grant_id;
      w_last_nxt  = r_last;
      w_hold_nxt  = r_hold;
      case (r_state)
         ST_IDLE: begin
            if (|req) begin
               w_state_nxt = ST_GRANT;
               w_id_nxt    = w_sel_id;
               w_last_nxt  = w_sel_id;
               w_hold_nxt  = '0;
            end
         end
         ST_GRANT: begin
            if (!req[r_grant_id]) begin
               w_state_nxt = ST_IDLE;
            end else if ((r_hold == HOLD_LIM) && w_others) begin
               w_state_nxt = ST_IDLE;
            end else if (r_hold != HOLD_LIM) begin
               w_hold_nxt = r_hold + 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_grant_id <= '0;
         r_last     <= ID_W'(N_REQ - 1);
         r_hold     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_grant_id <= w_id_nxt;
         r_last     <= w_last_nxt;
         r_hold     <= w_hold_nxt;
      end
   end

   assign grant    = w_dec & {N_REQ{w_busy}};
   assign grant_id = r_grant_id;
   assign busy     = w_busy;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Randomized and directed bench: three arbiters (hold limits 8, 3, 1) against a cycle-level model.
module tb_round_robin_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] req;
   logic [3:0] g   [3];
   logic [1:0] gid [3];
   logic       bsy [3];

   int n_cmp = 0;
   int n_bad = 0;

   int mh   [3] = '{8, 3, 1};
   int own  [3];
   int lst  [3];
   int held [3];

   always #5 clk = ~clk;

   round_robin_arbiter #(.MAX_HOLD(8)) dut8 (
      .clk(clk), .reset(reset), .req(req),
      .grant(g[0]), .grant_id(gid[0]), .busy(bsy[0]));
   round_robin_arbiter #(.MAX_HOLD(3)) dut3 (
      .clk(clk), .reset(reset), .req(req),
      .grant(g[1]), .grant_id(gid[1]), .busy(bsy[1]));
   round_robin_arbiter #(.MAX_HOLD(1)) dut1 (
      .clk(clk), .reset(reset), .req(req),
      .grant(g[2]), .grant_id(gid[2]), .busy(bsy[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: owner (-1 = nobody), pointer, and cycles owned so far.
   task automatic model_edge(input int d, input logic [3:0] r, input logic rst);
      int idx;
      if (rst) begin
         own[d] = -1; lst[d] = 3; held[d] = 0;
      end else if (own[d] < 0) begin
         for (int k = 1; k <= 4; k++) begin
            idx = (lst[d] + k) % 4;
            if (own[d] < 0 && r[idx]) begin
               own[d] = idx; lst[d] = idx; held[d] = 1;
            end
         end
      end else if (!r[own[d]]) begin
         own[d] = -1;
      end else if (held[d] >= mh[d] && (r & ~(4'b1 << own[d])) != 4'b0) begin
         own[d] = -1;
      end else begin
         held[d]++;
      end
   endtask

   // Called at a negedge: apply inputs, clock once, check all instances.
   task automatic step(input logic [3:0] r, input logic rst);
      logic [3:0] eg;
      req   = r;
      reset = rst;
      @(posedge clk);
      for (int d = 0; d < 3; d++) model_edge(d, r, rst);
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         eg = (own[d] < 0) ? 4'b0 : (4'b1 << own[d]);
         chk($sformatf("grant%0d", d), 32'(g[d]), 32'(eg));
         chk($sformatf("busy%0d", d), 32'(bsy[d]), 32'(own[d] >= 0));
         chk($sformatf("onehot%0d", d), 32'($onehot0(g[d])), 32'd1);
         if (rst) chk($sformatf("rst_id%0d", d), 32'(gid[d]), 32'd0);
         else if (own[d] >= 0) chk($sformatf("gid%0d", d), 32'(gid[d]), 32'(own[d]));
      end
   endtask

   initial begin
      logic [3:0] seq3 [17];
      logic [3:0] r;
      logic       rs;
      seq3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0000,
               4'b0010, 4'b0010, 4'b0010, 4'b0000,
               4'b0100, 4'b0100, 4'b0100, 4'b0000,
               4'b1000, 4'b1000, 4'b1000, 4'b0000,
               4'b0001};
      for (int d = 0; d < 3; d++) begin
         own[d] = -1; lst[d] = 3; held[d] = 0;
      end
      req   = 4'b0;
      reset = 1'b1;
      @(negedge clk);

      // Reset with all requesting, then the MAX_HOLD=3 rotation.
      step(4'b1111, 1'b1);
      chk("rst_grant", 32'(g[0]), 32'h0);
      for (int i = 0; i < 17; i++) begin
         step(4'b1111, 1'b0);
         if (i == 0) begin
            chk("first_grant", 32'(g[0]), 32'h1);
            chk("first_id", 32'(gid[0]), 32'h0);
         end
         chk($sformatf("rot3_%0d", i), 32'(g[1]), 32'(seq3[i]));
      end

      // Sole requester holds indefinitely.
      step(4'b0100, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step(4'b0100, 1'b0);
         chk($sformatf("sole_%0d", i), 32'(g[0]), 32'h4);
      end

      // Owner 2 drops; scan resumes at 3.
      step(4'b0000, 1'b1);
      step(4'b0100, 1'b0);
      chk("own2", 32'(g[0]), 32'h4);
      step(4'b1001, 1'b0);
      chk("drop_idle", 32'(g[0]), 32'h0);
      step(4'b1001, 1'b0);
      chk("drop_next", 32'(g[0]), 32'h8);

      // Owner 1 preempted after 8 cycles once requester 0 appears.
      step(4'b0000, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(4'b0010, 1'b0);
         chk($sformatf("hold_a%0d", i), 32'(g[0]), 32'h2);
      end
      for (int i = 0; i < 4; i++) begin
         step(4'b0011, 1'b0);
         chk($sformatf("hold_b%0d", i), 32'(g[0]), 32'h2);
      end
      step(4'b0011, 1'b0);
      chk("preempt_idle", 32'(g[0]), 32'h0);
      step(4'b0011, 1'b0);
      chk("preempt_next", 32'(g[0]), 32'h1);

      // Reset in owner 3's third cycle.
      step(4'b0000, 1'b1);
      for (int i = 0; i < 3; i++) step(4'b1000, 1'b0);
      chk("own3", 32'(g[0]), 32'h8);
      step(4'b1000, 1'b1);
      chk("midrst", 32'(g[0]), 32'h0);
      step(4'b1000, 1'b0);
      chk("after_rst", 32'(g[0]), 32'h8);

      // Randomized traffic with occasional reset.
      r = 4'b0;
      for (int n = 0; n < 3000; n++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
         rs = ($urandom_range(0, 299) == 0);
         step(r, rs);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
